// File: rtl/mpi_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mpi_slave_regs: MPI/Q-bus responder for the 177714/177716 I/O registers.   |
// | Optional MPI_SLAVE_WAIT_EN delays nRPLY by WAIT_CYCLES clocks.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mpi_slave_regs #(
  parameter logic [15:0] ADDR_PORT   = 16'o177714,
  parameter logic [15:0] ADDR_SYS    = 16'o177716,
  parameter logic [7:0]  SYS_HI      = 8'o200,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        CLKp,
  input  logic        nRESETp,
  inout  wire  [15:0] nADp,
  input  logic        nSYNCp,
  input  logic        nDINp,
  input  logic        nDOUTp,
  input  logic        nWTBTp,
  output wire         nRPLYp,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic [7:0]  sys_out,
  output logic        sel
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_RD_RPLY = 3'd3;
  localparam logic [2:0] ST_WR_RPLY = 3'd4;
  localparam logic [2:0] ST_END     = 3'd5;

  logic [15:0] addr_lat_q;
  logic [1:0]  sync_q, din_q, dout_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] port_q, port_d;
  logic [7:0]  sys_q, sys_d;
  logic        s_sync, s_din, s_dout;
  logic        hit_port, hit_sys, hit;
  logic        byte_wr;
  logic [15:0] wdata, rdata;
  logic        reply_entry, wait_done, rply_act, drive_act;

  // Address is taken straight off the bus at the nSYNC strobe, not on CLKp.
  always_ff @(negedge nSYNCp or negedge nRESETp) begin
    if (!nRESETp) addr_lat_q <= '0;
    else          addr_lat_q <= ~nADp;
  end

  always_ff @(posedge CLKp or negedge nRESETp) begin
    if (!nRESETp) begin
      sync_q <= 2'b11;
      din_q  <= 2'b11;
      dout_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], nSYNCp};
      din_q  <= {din_q[0], nDINp};
      dout_q <= {dout_q[0], nDOUTp};
    end
  end

  assign s_sync   = sync_q[1];
  assign s_din    = din_q[1];
  assign s_dout   = dout_q[1];
  assign hit_port = (addr_lat_q[15:1] == ADDR_PORT[15:1]);
  assign hit_sys  = (addr_lat_q[15:1] == ADDR_SYS[15:1]);
  assign hit      = hit_port | hit_sys;
  assign byte_wr  = ~nWTBTp;
  assign wdata    = ~nADp;
  assign rdata    = hit_sys ? {SYS_HI, sys_q} : port_in;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    sys_d   = sys_q;
    if (state_q != ST_IDLE && s_sync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (!s_sync) state_d = ST_DECODE;
        ST_DECODE: begin
          if (!hit) begin
            state_d = ST_END;
          end else if (!s_din) begin
            state_d = ST_RD_DATA;
          end else if (!s_dout) begin
            state_d = ST_WR_RPLY;
            if (hit_port) begin
              if (!byte_wr)          port_d       = wdata;
              else if (addr_lat_q[0]) port_d[15:8] = wdata[15:8];
              else                   port_d[7:0]  = wdata[7:0];
            end else if (!byte_wr || !addr_lat_q[0]) begin
              // The system register has no high byte; high-byte writes are dropped.
              sys_d = wdata[7:0];
            end
          end
        end
        ST_RD_DATA: state_d = ST_RD_RPLY;
        ST_RD_RPLY: if (s_din)  state_d = ST_END;
        ST_WR_RPLY: if (s_dout) state_d = ST_END;
        ST_END:     if (s_sync) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKp or negedge nRESETp) begin
    if (!nRESETp) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      sys_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      sys_q   <= sys_d;
    end
  end

  assign reply_entry = (state_d != state_q) &&
                       (state_d == ST_RD_RPLY || state_d == ST_WR_RPLY);

`ifdef MPI_SLAVE_WAIT_EN
  logic [7:0] wait_q;

  always_ff @(posedge CLKp or negedge nRESETp) begin
    if (!nRESETp)           wait_q <= '0;
    else if (reply_entry)   wait_q <= 8'(WAIT_CYCLES);
    else if (wait_q != 8'd0) wait_q <= wait_q - 8'd1;
  end

  assign wait_done = (wait_q == 8'd0);
`else
  logic unused_wait;
  assign unused_wait = reply_entry ^ (^WAIT_CYCLES);
  assign wait_done   = 1'b1;
`endif

  assign rply_act  = (state_q == ST_RD_RPLY || state_q == ST_WR_RPLY) && wait_done;
  assign drive_act = (state_q == ST_RD_DATA || state_q == ST_RD_RPLY);

  assign nRPLYp   = rply_act  ? 1'b0   : 1'bz;
  assign nADp     = drive_act ? ~rdata : 16'bz;
  assign port_out = port_q;
  assign sys_out  = sys_q;
  assign sel      = hit && (state_q == ST_DECODE || state_q == ST_RD_DATA ||
                            state_q == ST_RD_RPLY || state_q == ST_WR_RPLY);

endmodule
`default_nettype wire
